// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - MIPS fetch program counter with branch/jump/jr redirect, stall hold and IF/ID flush
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_base,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        redirect_pending,
    output logic        misaligned
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pend_target;
    logic [31:0] sel_target;
    logic        redirect;

    always_comb begin
        sel_target = branch_base + branch_offset;
        if (jr) begin
            sel_target = jr_target;
        end else if (jump) begin
            sel_target = {branch_base[31:28], jump_index, 2'b00};
        end
    end

    assign redirect         = jr | jump | branch_taken;
    assign pc_plus4         = pc + 32'd4;
    assign misaligned       = (pc[1:0] != 2'b00);
    assign redirect_pending = (state == HOLD);

    // In HOLD, fresh redirect pulses come from the wrong path; only the captured target is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            pend_target <= 32'h0000_0000;
            state       <= RUN;
            flush       <= 1'b0;
        end else begin
            flush <= 1'b0;
            case (state)
                RUN: begin
                    if (!stall) begin
                        if (redirect) begin
                            pc    <= sel_target;
                            flush <= 1'b1;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end else if (redirect) begin
                        pend_target <= sel_target;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc    <= pend_target;
                        flush <= 1'b1;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
